// File: rtl/jk_seq_ctrl_if.sv
// Handshake/status bundle between a stimulus source and the JK sequencer.
// master = stimulus side, slave = sequencer.
interface jk_seq_ctrl_if #(parameter int CNT_W = 8);
  logic             start;
  logic [1:0]       init_ab;
  logic [CNT_W-1:0] num_steps;
  logic             abort;
  logic             in_valid;
  logic             in_x;
  logic             in_y;
  logic             in_ready;
  logic             out_valid;
  logic             out_z;
  logic             out_a;
  logic             out_b;
  logic [CNT_W-1:0] z_count;
  logic             busy;
  logic             done;

  modport master (
    output start, init_ab, num_steps, abort, in_valid, in_x, in_y,
    input  in_ready, out_valid, out_z, out_a, out_b, z_count, busy, done
  );

  modport slave (
    input  start, init_ab, num_steps, abort, in_valid, in_x, in_y,
    output in_ready, out_valid, out_z, out_a, out_b, z_count, busy, done
  );
endinterface

// File: rtl/jk_seq_ctrl.sv
// Sequencer for the two-JK-flip-flop machine: loads {A,B}, then advances once per
// accepted (x,y) sample for a programmed step count, tracking z=1 steps.
module jk_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  jk_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic z;
  } jk_nxt_t;

  // z is Mealy: evaluated on the pre-update A,B together with the sample.
  function automatic jk_nxt_t jk_step(input logic a, input logic b,
                                      input logic x, input logic y);
    logic ja, ka, jb, kb;
    jk_nxt_t n;
    ja  = (~a & x) | (~b & y);
    ka  = b & ~x & ~y;
    jb  = ~a & x & y;
    kb  = ~a | (~b & x);
    n.a = (ja & ~a) | (~ka & a);
    n.b = (jb & ~b) | (~kb & b);
    n.z = (~a & ~x) | (~b & ~y);
    return n;
  endfunction

  state_t           state, state_nxt;
  logic             a_q, b_q;
  logic [CNT_W-1:0] cnt_q, zc_q;
  logic             ov_q, oz_q;
  logic             hs;
  logic             ld;
  jk_nxt_t          nxt;

  assign bus.in_ready  = (state == RUN) & ~bus.abort;
  assign hs            = bus.in_valid & bus.in_ready;
  assign nxt           = jk_step(a_q, b_q, bus.in_x, bus.in_y);
  assign bus.out_valid = ov_q;
  assign bus.out_z     = oz_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.z_count   = zc_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        ld        = 1'b1;
        state_nxt = (bus.num_steps != '0) ? RUN : DONE;
      end
      RUN: begin
        if (bus.abort)                      state_nxt = IDLE;
        else if (hs && cnt_q == CNT_W'(1))  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      cnt_q <= '0;
      zc_q  <= '0;
      ov_q  <= 1'b0;
      oz_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ov_q  <= hs;
      if (ld) begin
        {a_q, b_q} <= bus.init_ab;
        cnt_q      <= bus.num_steps;
        zc_q       <= '0;
      end else if (hs) begin
        a_q   <= nxt.a;
        b_q   <= nxt.b;
        oz_q  <= nxt.z;
        cnt_q <= cnt_q - CNT_W'(1);
        // Saturate rather than wrap once the count hits all-ones.
        if (nxt.z && zc_q != '1) zc_q <= zc_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl: an 8-bit instance for most scenarios and a
// 2-bit instance for count saturation.
module tb_jk_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   nassert = 0;
  int   nfail   = 0;

  always #5 clk = ~clk;

  jk_seq_ctrl_if #(.CNT_W(8)) bus8 ();
  jk_seq_ctrl_if #(.CNT_W(2)) bus2 ();

  jk_seq_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  jk_seq_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic v, input logic x, input logic y);
    bus8.in_valid = v;
    bus8.in_x     = x;
    bus8.in_y     = y;
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.start = 0; bus8.init_ab = 0; bus8.num_steps = 0; bus8.abort = 0;
    bus8.in_valid = 0; bus8.in_x = 0; bus8.in_y = 0;
    bus2.start = 0; bus2.init_ab = 0; bus2.num_steps = 0; bus2.abort = 0;
    bus2.in_valid = 0; bus2.in_x = 0; bus2.in_y = 0;
    tick(); tick();

    // reset state
    chk("rst busy", bus8.busy, 0);
    chk("rst ab", {bus8.out_a, bus8.out_b}, 2'b00);
    chk("rst zc", bus8.z_count, 0);
    chk("rst ov", bus8.out_valid, 0);
    chk("rst done", bus8.done, 0);
    chk("rst rdy", bus8.in_ready, 0);
    rst_n = 1'b1;

    // 1: 00, three steps (1,1),(0,0),(0,0)
    bus8.init_ab = 2'b00; bus8.num_steps = 3; bus8.start = 1;
    tick(); bus8.start = 0;
    chk("t1 busy", bus8.busy, 1);
    chk("t1 rdy", bus8.in_ready, 1);
    smp(1, 1, 1); tick();
    chk("t1 ov1", bus8.out_valid, 1);
    chk("t1 z1", bus8.out_z, 0);
    chk("t1 ab1", {bus8.out_a, bus8.out_b}, 2'b11);
    smp(1, 0, 0); tick();
    chk("t1 z2", bus8.out_z, 0);
    chk("t1 ab2", {bus8.out_a, bus8.out_b}, 2'b01);
    chk("t1 done2", bus8.done, 0);
    tick(); smp(0, 0, 0);
    chk("t1 ov3", bus8.out_valid, 1);
    chk("t1 z3", bus8.out_z, 1);
    chk("t1 ab3", {bus8.out_a, bus8.out_b}, 2'b00);
    chk("t1 zc", bus8.z_count, 1);
    chk("t1 done", bus8.done, 1);
    chk("t1 rdy done", bus8.in_ready, 0);
    tick();
    chk("t1 done off", bus8.done, 0);
    chk("t1 idle", bus8.busy, 0);
    chk("t1 ov off", bus8.out_valid, 0);
    chk("t1 zc hold", bus8.z_count, 1);

    // 2: num_steps=0, start held through DONE is not honoured again
    bus8.init_ab = 2'b10; bus8.num_steps = 0; bus8.start = 1;
    tick();
    chk("t2 done", bus8.done, 1);
    chk("t2 rdy", bus8.in_ready, 0);
    chk("t2 ab", {bus8.out_a, bus8.out_b}, 2'b10);
    bus8.init_ab = 2'b01;
    tick(); bus8.start = 0;
    chk("t2 idle", bus8.busy, 0);
    chk("t2 done off", bus8.done, 0);
    chk("t2 ab hold", {bus8.out_a, bus8.out_b}, 2'b10);
    chk("t2 ov", bus8.out_valid, 0);

    // 3: backpressure, num_steps=2, in_valid 1,0,0,1
    bus8.init_ab = 2'b00; bus8.num_steps = 2; bus8.start = 1;
    tick(); bus8.start = 0;
    smp(1, 1, 1); tick();
    chk("t3 ov1", bus8.out_valid, 1);
    chk("t3 ab1", {bus8.out_a, bus8.out_b}, 2'b11);
    smp(0, 0, 0); tick();
    chk("t3 gap1 ov", bus8.out_valid, 0);
    chk("t3 gap1 ab", {bus8.out_a, bus8.out_b}, 2'b11);
    tick();
    chk("t3 gap2 ov", bus8.out_valid, 0);
    chk("t3 gap2 ab", {bus8.out_a, bus8.out_b}, 2'b11);
    smp(1, 0, 0); tick();
    chk("t3 ov2", bus8.out_valid, 1);
    chk("t3 ab2", {bus8.out_a, bus8.out_b}, 2'b01);
    chk("t3 done", bus8.done, 1);
    tick();
    chk("t3 idle ov", bus8.out_valid, 0);
    chk("t3 idle", bus8.busy, 0);
    // in_valid still high in IDLE: ignored
    tick(); smp(0, 0, 0);
    chk("t3 ign ov", bus8.out_valid, 0);
    chk("t3 ign ab", {bus8.out_a, bus8.out_b}, 2'b01);

    // 4: abort after 1 of 4 steps
    bus8.init_ab = 2'b00; bus8.num_steps = 4; bus8.start = 1;
    tick(); bus8.start = 0;
    smp(1, 1, 0); tick();
    chk("t4 ov1", bus8.out_valid, 1);
    chk("t4 z1", bus8.out_z, 1);
    chk("t4 ab1", {bus8.out_a, bus8.out_b}, 2'b10);
    bus8.abort = 1; smp(1, 0, 0); #1;
    chk("t4 rdy abort", bus8.in_ready, 0);
    tick();
    chk("t4 busy", bus8.busy, 0);
    chk("t4 ov", bus8.out_valid, 0);
    chk("t4 done", bus8.done, 0);
    chk("t4 ab", {bus8.out_a, bus8.out_b}, 2'b10);
    chk("t4 zc", bus8.z_count, 1);
    bus8.abort = 0; smp(0, 0, 0); tick();
    chk("t4 done later", bus8.done, 0);

    // 6: start inside RUN ignored, then reset mid-run
    bus8.init_ab = 2'b00; bus8.num_steps = 4; bus8.start = 1;
    tick(); bus8.start = 0;
    smp(1, 1, 0); tick();
    chk("t6 ab1", {bus8.out_a, bus8.out_b}, 2'b10);
    smp(0, 0, 0); bus8.init_ab = 2'b11; bus8.num_steps = 1; bus8.start = 1;
    tick(); bus8.start = 0;
    chk("t6 ab kept", {bus8.out_a, bus8.out_b}, 2'b10);
    chk("t6 busy", bus8.busy, 1);
    smp(1, 0, 0); tick();
    chk("t6 z2", bus8.out_z, 1);
    chk("t6 ab2", {bus8.out_a, bus8.out_b}, 2'b10);
    chk("t6 zc2", bus8.z_count, 2);
    chk("t6 no done", bus8.done, 0);
    chk("t6 still run", bus8.busy, 1);
    rst_n = 1'b0; tick();
    chk("t6 rst busy", bus8.busy, 0);
    chk("t6 rst ab", {bus8.out_a, bus8.out_b}, 2'b00);
    chk("t6 rst zc", bus8.z_count, 0);
    chk("t6 rst ov", bus8.out_valid, 0);
    chk("t6 rst done", bus8.done, 0);
    rst_n = 1'b1; smp(0, 0, 0); tick();

    // 5: CNT_W=2, init 01, three (0,0) samples
    bus2.init_ab = 2'b01; bus2.num_steps = 3; bus2.start = 1;
    tick(); bus2.start = 0;
    bus2.in_valid = 1; bus2.in_x = 0; bus2.in_y = 0;
    tick();
    chk("t5 z1", bus2.out_z, 1);
    chk("t5 ab1", {bus2.out_a, bus2.out_b}, 2'b00);
    chk("t5 zc1", bus2.z_count, 1);
    tick();
    chk("t5 z2", bus2.out_z, 1);
    chk("t5 zc2", bus2.z_count, 2);
    tick(); bus2.in_valid = 0;
    chk("t5 z3", bus2.out_z, 1);
    chk("t5 zc3", bus2.z_count, 3);
    chk("t5 done", bus2.done, 1);
    tick();
    chk("t5 zc hold", bus2.z_count, 3);
    chk("t5 idle", bus2.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
